// File: rtl/pc_sequencer_if.sv
// Fetch/command bundle between pc_sequencer, the program ROM and nbit_pc.
// master = sequencer side, slave = the ROM/PC side that feeds it.
interface pc_sequencer_if #(
  parameter int N  = 4,
  parameter int IW = 8
);
  logic          start;
  logic [N-1:0]  pc_out;
  logic          mem_req;
  logic          mem_ack;
  logic [IW-1:0] instr;
  logic [1:0]    ctrl;
  logic [N-1:0]  pc_in;
  logic          busy;
  logic          done;

  modport master (
    input  start, pc_out, mem_ack, instr,
    output mem_req, ctrl, pc_in, busy, done
  );

  modport slave (
    output start, pc_out, mem_ack, instr,
    input  mem_req, ctrl, pc_in, busy, done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction fetch/decode sequencer driving nbit_pc's ctrl/pc_in commands.
// All outputs are registered from the next state, so none follows an input combinationally.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start, PC held
// INIT    | one cycle, loads START_ADDR into the PC
// FETCH   | mem_req high until mem_ack, instruction captured on ack
// EXEC    | one cycle, PC command from the decoded instruction
// HALTED  | program finished, done high, start re-runs from INIT
module pc_sequencer #(
  parameter int           N          = 4,
  parameter int           IW         = 8,
  parameter logic [N-1:0] START_ADDR = '0
) (
  input  logic          clk,
  input  logic          clr,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_INC1 = 2'b10;
  localparam logic [1:0] PC_INC2 = 2'b11;

  state_t        state_q,    state_d;
  logic [IW-1:0] instr_q,    instr_d;
  logic [3:0]    loop_cnt_q, loop_cnt_d;
  logic [1:0]    ctrl_q,     ctrl_d;
  logic [N-1:0]  pc_in_q,    pc_in_d;
  logic          mem_req_q,  mem_req_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;

  logic [1:0] cur_op, nxt_op;
  logic       cur_mod, nxt_mod;
  logic [3:0] cur_imm, nxt_tgt;

  // pc_out addresses the ROM directly; bit 4 and bits above 7 carry no meaning.
  logic sig_unused;
  assign sig_unused = ^{bus.pc_out, instr_q & ~IW'(8'hEF)};

  always_comb begin
    cur_op     = instr_q[7:6];
    cur_mod    = instr_q[5];
    cur_imm    = instr_q[3:0];

    state_d    = state_q;
    instr_d    = instr_q;
    loop_cnt_d = loop_cnt_q;

    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack) begin
          instr_d = bus.instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (cur_op == 2'b11 && !cur_mod) state_d = S_HALTED;
        if (cur_op == 2'b01 && cur_mod && loop_cnt_q != 4'd0) loop_cnt_d = loop_cnt_q - 4'd1;
        if (cur_op == 2'b11 && cur_mod) loop_cnt_d = cur_imm;
      end
      S_HALTED: if (bus.start) state_d = S_INIT;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are those of the state being entered; an EXEC command is
    // decoded from the word being captured, loop_cnt is stable across FETCH.
    nxt_op    = instr_d[7:6];
    nxt_mod   = instr_d[5];
    nxt_tgt   = instr_d[3:0];
    ctrl_d    = PC_HOLD;
    pc_in_d   = '0;
    mem_req_d = (state_d == S_FETCH);
    busy_d    = (state_d == S_INIT) || (state_d == S_FETCH) || (state_d == S_EXEC);
    done_d    = (state_d == S_HALTED);

    if (state_d == S_INIT) begin
      ctrl_d  = PC_LOAD;
      pc_in_d = START_ADDR;
    end else if (state_d == S_EXEC) begin
      case (nxt_op)
        2'b00: ctrl_d = PC_INC1;
        2'b01: begin
          if (!nxt_mod || loop_cnt_q != 4'd0) begin
            ctrl_d  = PC_LOAD;
            pc_in_d = N'(nxt_tgt);
          end else begin
            ctrl_d  = PC_INC1;
          end
        end
        2'b10:   ctrl_d = PC_INC2;
        default: ctrl_d = nxt_mod ? PC_INC1 : PC_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      loop_cnt_q <= '0;
      ctrl_q     <= PC_HOLD;
      pc_in_q    <= '0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      loop_cnt_q <= loop_cnt_d;
      ctrl_q     <= ctrl_d;
      pc_in_q    <= pc_in_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ctrl    = ctrl_q;
  assign bus.pc_in   = pc_in_q;
  assign bus.mem_req = mem_req_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural nbit_pc and ROM; per-cycle
// expected traces are hand-computed tables.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.N(4), .IW(8)) bus ();

  pc_sequencer #(.N(4), .IW(8), .START_ADDR(4'd0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [7:0] rom [16];
  logic [3:0] pc;
  int         wcnt;
  int         ack_delay;
  bit         ack_en;

  always @(posedge clk) begin
    if (clr) pc <= 4'd0;
    else case (bus.ctrl)
      2'b01:   pc <= bus.pc_in;
      2'b10:   pc <= pc + 4'd1;
      2'b11:   pc <= pc + 4'd2;
      default: pc <= pc;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  assign bus.pc_out  = pc;
  assign bus.mem_ack = ack_en && bus.mem_req && (wcnt >= ack_delay);
  // HALT word off-ack: sampling without mem_ack would end the run early
  assign bus.instr   = bus.mem_ack ? rom[pc] : 8'hC0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int exp_ctrl [32];
  int exp_pcin [32];
  int exp_req  [32];
  int exp_pc   [32];
  int exp_lc   [32];
  bit start_drv[32];
  int nrows;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_trace();
    nrows = 0;
    for (int i = 0; i < 32; i++) start_drv[i] = 1'b0;
    start_drv[0] = 1'b1;
  endtask

  task automatic row(input int c, input int pi, input int rq, input int p, input int lc);
    exp_ctrl[nrows] = c;
    exp_pcin[nrows] = pi;
    exp_req[nrows]  = rq;
    exp_pc[nrows]   = p;
    exp_lc[nrows]   = lc;
    nrows++;
  endtask

  task automatic run_trace(input string tag);
    for (int i = 0; i < nrows; i++) begin
      bus.start = start_drv[i];
      tick();
      check($sformatf("%s[%0d].ctrl", tag, i), 32'(bus.ctrl), exp_ctrl[i]);
      check($sformatf("%s[%0d].mem_req", tag, i), 32'(bus.mem_req), exp_req[i]);
      check($sformatf("%s[%0d].busy", tag, i), 32'(bus.busy), 1);
      check($sformatf("%s[%0d].done", tag, i), 32'(bus.done), 0);
      if (exp_pcin[i] >= 0) check($sformatf("%s[%0d].pc_in", tag, i), 32'(bus.pc_in), exp_pcin[i]);
      if (exp_pc[i] >= 0)   check($sformatf("%s[%0d].pc_out", tag, i), 32'(pc), exp_pc[i]);
      if (exp_lc[i] >= 0)   check($sformatf("%s[%0d].loop_cnt", tag, i), 32'(dut.loop_cnt_q), exp_lc[i]);
    end
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic rom_fill();
    for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
  endtask

  task automatic expect_halted(input string tag, input int p);
    tick();
    check({tag, ".done"}, 32'(bus.done), 1);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".ctrl"}, 32'(bus.ctrl), 0);
    check({tag, ".pc_out"}, 32'(pc), p);
  endtask

  initial begin
    bus.start = 1'b0;
    ack_en    = 1'b1;
    ack_delay = 0;
    rom_fill();

    do_reset();
    check("reset.ctrl", 32'(bus.ctrl), 0);
    check("reset.pc_in", 32'(bus.pc_in), 0);
    check("reset.mem_req", 32'(bus.mem_req), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.done", 32'(bus.done), 0);
    check("reset.loop_cnt", 32'(dut.loop_cnt_q), 0);

    // 1: clear while stuck in FETCH
    rom[0] = 8'h00;
    ack_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("t1.fetch.mem_req", 32'(bus.mem_req), 1);
    check("t1.fetch.busy", 32'(bus.busy), 1);
    check("t1.fetch.ctrl", 32'(bus.ctrl), 0);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    check("t1.clr.mem_req", 32'(bus.mem_req), 0);
    check("t1.clr.ctrl", 32'(bus.ctrl), 0);
    check("t1.clr.busy", 32'(bus.busy), 0);
    check("t1.clr.done", 32'(bus.done), 0);
    tick();
    check("t1.idle.mem_req", 32'(bus.mem_req), 0);
    check("t1.idle.busy", 32'(bus.busy), 0);
    ack_en = 1'b1;

    // 2: NOP, SKIP, JMP 6, HALT
    do_reset();
    rom_fill();
    rom[0] = 8'h00; rom[1] = 8'h80; rom[3] = 8'h46; rom[6] = 8'hC0;
    new_trace();
    row(1, 0, 0, 0, -1);
    row(0, -1, 1, 0, -1);
    row(2, -1, 0, 0, -1);
    row(0, -1, 1, 1, -1);
    row(3, -1, 0, 1, -1);
    row(0, -1, 1, 3, -1);
    row(1, 6, 0, 3, -1);
    row(0, -1, 1, 6, -1);
    row(0, -1, 0, 6, -1);
    run_trace("t2");
    expect_halted("t2.end", 6);

    // 3: LDC 3, DJNZ 1 loop, HALT
    do_reset();
    rom_fill();
    rom[0] = 8'hE3; rom[1] = 8'h61; rom[2] = 8'hC0;
    new_trace();
    row(1, 0, 0, 0, 0);
    row(0, -1, 1, 0, 0);
    row(2, -1, 0, 0, 0);
    row(0, -1, 1, 1, 3);
    row(1, 1, 0, 1, 3);
    row(0, -1, 1, 1, 2);
    row(1, 1, 0, 1, 2);
    row(0, -1, 1, 1, 1);
    row(1, 1, 0, 1, 1);
    row(0, -1, 1, 1, 0);
    row(2, -1, 0, 1, 0);
    row(0, -1, 1, 2, 0);
    row(0, -1, 0, 2, 0);
    run_trace("t3");
    expect_halted("t3.end", 2);
    check("t3.end.loop_cnt", 32'(dut.loop_cnt_q), 0);

    // 4: three wait cycles per fetch
    do_reset();
    rom_fill();
    rom[0] = 8'h00; rom[1] = 8'hC0;
    ack_delay = 3;
    new_trace();
    row(1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) row(0, -1, 1, 0, -1);
    row(2, -1, 0, 0, -1);
    for (int i = 0; i < 4; i++) row(0, -1, 1, 1, -1);
    row(0, -1, 0, 1, -1);
    run_trace("t4");
    expect_halted("t4.end", 1);
    ack_delay = 0;

    // 5: start while busy ignored, start from HALTED restarts
    do_reset();
    new_trace();
    for (int i = 1; i < 5; i++) start_drv[i] = 1'b1;
    row(1, 0, 0, 0, -1);
    row(0, -1, 1, 0, -1);
    row(2, -1, 0, 0, -1);
    row(0, -1, 1, 1, -1);
    row(0, -1, 0, 1, -1);
    run_trace("t5a");
    expect_halted("t5a.end", 1);
    new_trace();
    row(1, 0, 0, 1, -1);
    row(0, -1, 1, 0, -1);
    run_trace("t5b");

    // 6: wrap 15 -> 0; loop_cnt kept across start
    do_reset();
    rom_fill();
    rom[0] = 8'hE1; rom[1] = 8'hC0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 50 && !bus.done; k++) tick();
    check("t6.pre.done", 32'(bus.done), 1);
    check("t6.pre.loop_cnt", 32'(dut.loop_cnt_q), 1);
    rom[0] = 8'h6F; rom[15] = 8'h00;
    new_trace();
    row(1, 0, 0, 1, 1);
    row(0, -1, 1, 0, 1);
    row(1, 15, 0, 0, 1);
    row(0, -1, 1, 15, 0);
    row(2, -1, 0, 15, 0);
    row(0, -1, 1, 0, 0);
    row(2, -1, 0, 0, 0);
    row(0, -1, 1, 1, 0);
    row(0, -1, 0, 1, 0);
    run_trace("t6");
    expect_halted("t6.end", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
